// File: rtl/lab1_imul_accum_pkg.sv
// ---------------------------------------------------------------------------
// lab1_imul_accum_pkg
//   Shared definitions for the multiplier response accumulator:
//   the controller state encoding and the default widths.
//   Imported by lab1_imul_resp_accum and lab1_imul_resp_accum_dpath.
// ---------------------------------------------------------------------------
package lab1_imul_accum_pkg;

    // Default widths: 32-bit products/sum, 8-bit run length.
    localparam int P_NBITS     = 32;
    localparam int P_LEN_NBITS = 8;

    // Controller states. Encoding 2'b11 is unused and treated as illegal.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/lab1_imul_resp_accum_dpath.sv
// ---------------------------------------------------------------------------
// lab1_imul_resp_accum_dpath
//   Datapath of the response accumulator: running sum, sticky carry-out
//   flag and the run-length down-counter.
//
//   Ports
//     clk           in   clock, rising edge
//     reset         in   asynchronous active-low reset
//     cfg_len       in   run length, loaded on cnt_ld
//     in_msg        in   product to accumulate on sum_en
//     sum_clr       in   clear sum and ovf
//     sum_en        in   sum <= sum + in_msg, ovf |= carry
//     cnt_ld        in   remain <= cfg_len
//     cnt_dec       in   remain <= remain - 1
//     remain_is_one out  remain == 1 (current product is the last one)
//     len_is_zero   out  cfg_len == 0 (empty run)
//     sum           out  registered sum
//     ovf           out  registered sticky carry flag
// ---------------------------------------------------------------------------
module lab1_imul_resp_accum_dpath
    import lab1_imul_accum_pkg::*;
#(
    parameter int p_nbits     = P_NBITS,
    parameter int p_len_nbits = P_LEN_NBITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_len_nbits-1:0] cfg_len,
    input  logic [p_nbits-1:0]     in_msg,
    input  logic                   sum_clr,
    input  logic                   sum_en,
    input  logic                   cnt_ld,
    input  logic                   cnt_dec,
    output logic                   remain_is_one,
    output logic                   len_is_zero,
    output logic [p_nbits-1:0]     sum,
    output logic                   ovf
);

    logic [p_nbits-1:0]     sum_q;
    logic                   ovf_q;
    logic [p_len_nbits-1:0] remain_q;
    logic [p_nbits:0]       add_full;

    // One extra bit so the MSB is the unsigned carry-out of the add.
    assign add_full = {1'b0, sum_q} + {1'b0, in_msg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (sum_clr) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (sum_en) begin
            sum_q <= add_full[p_nbits-1:0];
            ovf_q <= ovf_q | add_full[p_nbits];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remain_q <= '0;
        end else if (cnt_ld) begin
            remain_q <= cfg_len;
        end else if (cnt_dec) begin
            remain_q <= remain_q - p_len_nbits'(1);
        end
    end

    assign remain_is_one = (remain_q == p_len_nbits'(1));
    assign len_is_zero   = (cfg_len == '0);
    assign sum           = sum_q;
    assign ovf           = ovf_q;

endmodule

// File: rtl/lab1_imul_resp_accum.sv
// ---------------------------------------------------------------------------
// lab1_imul_resp_accum
//   Consumes the multiplier response stream: takes a run length on the cfg
//   port, accepts exactly that many products on the in port, then presents
//   their sum (mod 2^p_nbits) plus a sticky carry flag on the out port.
//
//   Handshakes: every port transfers on a rising edge where val && rdy.
//   rdy/val outputs here come from state only and never look at the
//   partner's val/rdy; only the current state's rdy or val is ever high.
//
//   Ports
//     clk       in   clock, rising edge
//     reset     in   asynchronous active-low reset
//     cfg_val   in   run length valid
//     cfg_rdy   out  ready for run length (IDLE)
//     cfg_len   in   products in this run, 0 legal
//     in_val    in   product valid
//     in_rdy    out  ready for product (ACCUM)
//     in_msg    in   product
//     out_val   out  sum valid (DONE)
//     out_rdy   in   sink ready
//     out_msg   out  sum, zero outside DONE
//     out_ovf   out  sticky carry flag, zero outside DONE
//     dbg_state out  current controller state encoding
// ---------------------------------------------------------------------------
module lab1_imul_resp_accum
    import lab1_imul_accum_pkg::*;
#(
    parameter int p_nbits     = P_NBITS,
    parameter int p_len_nbits = P_LEN_NBITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_val,
    output logic                   cfg_rdy,
    input  logic [p_len_nbits-1:0] cfg_len,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_nbits-1:0]     in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_nbits-1:0]     out_msg,
    output logic                   out_ovf,
    output logic [1:0]             dbg_state
);

    state_t             state, state_next;
    logic               sum_clr, sum_en, cnt_ld, cnt_dec;
    logic               remain_is_one, len_is_zero;
    logic [p_nbits-1:0] sum;
    logic               ovf;

    lab1_imul_resp_accum_dpath #(
        .p_nbits     (p_nbits),
        .p_len_nbits (p_len_nbits)
    ) u_dpath (
        .clk           (clk),
        .reset         (reset),
        .cfg_len       (cfg_len),
        .in_msg        (in_msg),
        .sum_clr       (sum_clr),
        .sum_en        (sum_en),
        .cnt_ld        (cnt_ld),
        .cnt_dec       (cnt_dec),
        .remain_is_one (remain_is_one),
        .len_is_zero   (len_is_zero),
        .sum           (sum),
        .ovf           (ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cfg_rdy    = 1'b0;
        in_rdy     = 1'b0;
        out_val    = 1'b0;
        out_msg    = '0;
        out_ovf    = 1'b0;
        sum_clr    = 1'b0;
        sum_en     = 1'b0;
        cnt_ld     = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_rdy = 1'b1;
                if (cfg_val) begin
                    sum_clr    = 1'b1;
                    cnt_ld     = 1'b1;
                    state_next = len_is_zero ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    sum_en  = 1'b1;
                    cnt_dec = 1'b1;
                    if (remain_is_one) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // cfg_rdy stays low here even when out fires, so a new run
                // can only start the cycle after the sum is taken.
                out_val = 1'b1;
                out_msg = sum;
                out_ovf = ovf;
                if (out_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cfg_rdy    = 1'bx;
                in_rdy     = 1'bx;
                out_val    = 1'bx;
                out_msg    = 'x;
                out_ovf    = 1'bx;
                sum_clr    = 1'bx;
                sum_en     = 1'bx;
                cnt_ld     = 1'bx;
                cnt_dec    = 1'bx;
            end
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_lab1_imul_resp_accum.sv
// ---------------------------------------------------------------------------
// tb_lab1_imul_resp_accum
//   Directed bench for the response accumulator. Inputs change 1 time unit
//   after a rising edge; outputs are sampled on the falling edge or 1 unit
//   after the rising edge.
// ---------------------------------------------------------------------------
module tb_lab1_imul_resp_accum;

    logic        clk;
    logic        reset;
    logic        cfg_val;
    logic        cfg_rdy;
    logic [7:0]  cfg_len;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_msg;
    logic        out_ovf;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int fire_cnt = 0;

    lab1_imul_resp_accum dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_val   (cfg_val),
        .cfg_rdy   (cfg_rdy),
        .cfg_len   (cfg_len),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_msg    (in_msg),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg),
        .out_ovf   (out_ovf),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Product handshakes that will fire at the coming rising edge.
    always @(negedge clk) begin
        if (reset && in_val && in_rdy) fire_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a run length and hold it until it is taken.
    task automatic do_cfg(input logic [7:0] len);
        bit ok;
        ok      = 1'b0;
        cfg_val = 1'b1;
        cfg_len = len;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cfg_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check("cfg_accept_timeout", 32'(ok), 32'd1);
        tick();
        cfg_val = 1'b0;
    endtask

    // Present one product and hold it until it is taken.
    task automatic feed(input logic [31:0] data);
        bit ok;
        ok     = 1'b0;
        in_val = 1'b1;
        in_msg = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check("in_accept_timeout", 32'(ok), 32'd1);
        tick();
        in_val = 1'b0;
    endtask

    // Take the sum in the current cycle (assumes out_val is high now).
    task automatic consume();
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        reset   = 1'b0;
        cfg_val = 1'b0;
        cfg_len = '0;
        in_val  = 1'b0;
        in_msg  = '0;
        out_rdy = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_rdy", 32'(cfg_rdy), 32'd1);
        check("rst_in_rdy",  32'(in_rdy),  32'd0);
        check("rst_out_val", 32'(out_val), 32'd0);
        check("rst_out_msg", out_msg,      32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        reset = 1'b1;
        tick();

        // 1: len 3, products 2,3,4 back-to-back -> 9
        do_cfg(8'd3);
        check("t1_in_rdy", 32'(in_rdy), 32'd1);
        feed(32'd2);
        feed(32'd3);
        in_val = 1'b1;
        in_msg = 32'd4;
        @(negedge clk);
        check("t1_val_before_last", 32'(out_val), 32'd0);
        tick();
        in_val = 1'b0;
        check("t1_out_val", 32'(out_val), 32'd1);
        check("t1_out_msg", out_msg,      32'd9);
        check("t1_out_ovf", 32'(out_ovf), 32'd0);
        check("t1_in_rdy_done", 32'(in_rdy), 32'd0);
        consume();
        check("t1_back_idle", 32'(cfg_rdy), 32'd1);
        check("t1_out_val_low", 32'(out_val), 32'd0);

        // 2: len 0 -> result the next cycle, no product accepted
        do_cfg(8'd0);
        check("t2_in_rdy", 32'(in_rdy),  32'd0);
        check("t2_out_val", 32'(out_val), 32'd1);
        check("t2_out_msg", out_msg,      32'd0);
        check("t2_cfg_rdy", 32'(cfg_rdy), 32'd0);
        consume();

        // 3: carry-out sets the sticky flag, next run clears it
        do_cfg(8'd2);
        feed(32'hFFFF_FFFF);
        feed(32'h0000_0002);
        check("t3_out_msg", out_msg,      32'h0000_0001);
        check("t3_out_ovf", 32'(out_ovf), 32'd1);
        consume();
        do_cfg(8'd1);
        feed(32'd5);
        check("t3b_out_msg", out_msg,      32'd5);
        check("t3b_out_ovf", 32'(out_ovf), 32'd0);
        consume();

        // 4: sink stall holds the result; cfg offered during DONE is refused
        do_cfg(8'd2);
        feed(32'd6);
        feed(32'd7);
        cfg_val = 1'b1;
        cfg_len = 8'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_val", 32'(out_val), 32'd1);
            check("t4_stall_msg", out_msg,      32'd13);
            check("t4_stall_cfg", 32'(cfg_rdy), 32'd0);
        end
        #1;
        consume();
        check("t4_cfg_rdy_after", 32'(cfg_rdy), 32'd1);
        check("t4_no_overlap",    32'(in_rdy),  32'd0);
        cfg_val = 1'b0;
        tick();

        // 5: asynchronous reset in the middle of a run
        do_cfg(8'd4);
        feed(32'd10);
        feed(32'd20);
        #3;
        reset = 1'b0;
        #1;
        check("t5_cfg_rdy", 32'(cfg_rdy), 32'd1);
        check("t5_in_rdy",  32'(in_rdy),  32'd0);
        check("t5_out_val", 32'(out_val), 32'd0);
        check("t5_out_msg", out_msg,      32'd0);
        check("t5_out_ovf", 32'(out_ovf), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        do_cfg(8'd1);
        feed(32'd7);
        check("t5_out_val2", 32'(out_val), 32'd1);
        check("t5_out_msg2", out_msg,      32'd7);
        consume();

        // 6: longest run, random source gaps and sink stalls
        fire_cnt = 0;
        do_cfg(8'd255);
        for (int i = 0; i < 255; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            feed(32'd1);
        end
        check("t6_out_val", 32'(out_val), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            out_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("t6_hold_msg", out_msg, 32'd255);
            if (out_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_out_fire", 32'(ok), 32'd1);
        check("t6_out_ovf", 32'(out_ovf), 32'd0);
        tick();
        out_rdy = 1'b0;
        check("t6_fire_cnt", 32'(fire_cnt), 32'd255);
        check("t6_idle", 32'(cfg_rdy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
